// File: rtl/m_lsu.sv
// RV32 load/store unit: one outstanding access, aligned-only, with a
// mem_ack timeout; load lanes are extracted and extended locally.
module m_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CLOG = $clog2(TIMEOUT + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_legal;
    logic          req_mis;
    logic [3:0]    st_strb;
    logic [31:0]   st_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    always_comb begin
        req_legal = 1'b0;
        req_mis   = 1'b0;
        st_strb   = 4'b0000;
        st_data   = req_wdata;
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
        case (req_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_mis = req_addr[0];
                st_strb = 4'b0011 << req_addr[1:0];
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                req_mis = (req_addr[1:0] != 2'b00);
                st_strb = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        f3_d         = f3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    off_d = req_addr[1:0];
                    if (!req_legal || req_mis) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_we ? st_data : 32'd0;
                        mem_wstrb_d = req_we ? st_strb : 4'b0000;
                        cnt_d       = '0;
                    end
                end
            end
            ACCESS: begin
                // ack wins over a timeout landing in the same cycle
                if (mem_ack || cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !mem_ack;
                    resp_rdata_d = (mem_ack && !mem_we_q) ? ld_data : 32'd0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = 32'd0;
                    mem_wdata_d  = 32'd0;
                    mem_wstrb_d  = 4'b0000;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_m_lsu.sv
// Bench for m_lsu: table-driven accesses with a response scoreboard,
// plus timeout, stray-ack and reset-during-access sequences.
module tb_m_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    m_lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;
        bit          tmo;
        logic        err;
        logic [31:0] rd;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  strb;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[14];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid 1 expected 0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_rdata", resp_rdata, e.rd);
            end
        end
    end

    task automatic run(input vec_t v);
        int  lat;
        int  reqs;
        int  exp_lat;
        int  exp_reqs;
        bit  done;
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.err = v.err;
        e.rd  = v.rd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat  = 0;
        reqs = 0;
        done = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                reqs++;
                chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
                chk("mem_addr", mem_addr, v.maddr);
                chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.strb});
                if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
                if (v.d != 0 && reqs == v.d) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (resp_valid) begin
                lat  = c;
                done = 1;
            end
        end
        mem_ack = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_wait: got no resp_valid expected one within 20 cycles");
        end
        exp_lat  = v.tmo ? 5 : (v.err ? 1 : v.d + 1);
        exp_reqs = v.tmo ? 4 : (v.err ? 0 : v.d);
        chk("latency", lat, exp_lat);
        chk("mem_req_cycles", reqs, exp_reqs);
        @(negedge clk);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
        chk("resp_valid_low", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        bit seen;
        tbl[0]  = '{0, 3'b100, 32'h13,  32'h0,        32'h80FF1234, 1, 0, 0,
                    32'h00000080, 32'h10,  32'h0,        4'h0};
        tbl[1]  = '{0, 3'b001, 32'h22,  32'h0,        32'h80017FFF, 2, 0, 0,
                    32'hFFFF8001, 32'h20,  32'h0,        4'h0};
        tbl[2]  = '{0, 3'b101, 32'h22,  32'h0,        32'h80017FFF, 1, 0, 0,
                    32'h00008001, 32'h20,  32'h0,        4'h0};
        tbl[3]  = '{1, 3'b000, 32'h105, 32'h123456AB, 32'h0,        3, 0, 0,
                    32'h0,        32'h104, 32'hABABABAB, 4'h2};
        tbl[4]  = '{0, 3'b010, 32'h6,   32'h0,        32'h0,        0, 0, 1,
                    32'h0,        32'h0,   32'h0,        4'h0};
        tbl[5]  = '{1, 3'b011, 32'h8,   32'h55,       32'h0,        0, 0, 1,
                    32'h0,        32'h0,   32'h0,        4'h0};
        tbl[6]  = '{0, 3'b000, 32'h21,  32'h0,        32'h00008000, 1, 0, 0,
                    32'hFFFFFF80, 32'h20,  32'h0,        4'h0};
        tbl[7]  = '{1, 3'b001, 32'h32,  32'hDEADBEEF, 32'h0,        2, 0, 0,
                    32'h0,        32'h30,  32'hBEEFBEEF, 4'hC};
        tbl[8]  = '{1, 3'b010, 32'h44,  32'hCAFEF00D, 32'h0,        1, 0, 0,
                    32'h0,        32'h44,  32'hCAFEF00D, 4'hF};
        tbl[9]  = '{0, 3'b010, 32'h48,  32'h0,        32'h12345678, 3, 0, 0,
                    32'h12345678, 32'h48,  32'h0,        4'h0};
        tbl[10] = '{0, 3'b001, 32'h23,  32'h0,        32'h0,        0, 0, 1,
                    32'h0,        32'h0,   32'h0,        4'h0};
        tbl[11] = '{0, 3'b110, 32'h10,  32'h0,        32'h0,        0, 0, 1,
                    32'h0,        32'h0,   32'h0,        4'h0};
        tbl[12] = '{0, 3'b000, 32'h3,   32'h0,        32'h7F000000, 1, 0, 0,
                    32'h0000007F, 32'h0,   32'h0,        4'h0};
        tbl[13] = '{0, 3'b010, 32'h50,  32'h0,        32'h0,        0, 1, 1,
                    32'h0,        32'h50,  32'h0,        4'h0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(tbl[i]);

        // stray ack in the IDLE cycle right after the timeout response
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        chk("stray_ready", {31'd0, req_ready}, 32'd1);

        // reset in the middle of a sw access
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsta_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rsta_mem_wdata", mem_wdata, 32'h11223344);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsta_mem_req_low", {31'd0, mem_req}, 32'd0);
        chk("rsta_ready", {31'd0, req_ready}, 32'd1);
        chk("rsta_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rsta_mem_addr", mem_addr, 32'd0);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        seen    = 0;
        @(negedge clk);
        mem_ack = 1'b0;
        seen |= resp_valid;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        chk("rsta_no_resp", {31'd0, seen}, 32'd0);
        chk("rsta_idle_req", {31'd0, mem_req}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_lsu.md
M_LSU -- requirements
Module: m_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles mem_req may stay high without mem_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req_valid, input, 1 bit: the CPU presents a load/store.
REQ-005 SHALL have port req_ready, output, 1 bit: the LSU can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RISC-V funct3 of the load/store instruction.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: rs2 value for stores.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: extended load data.
REQ-012 SHALL have port resp_err, output, 1 bit: the access was misaligned, illegal or timed out; valid with resp_valid.
REQ-013 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-014 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-015 SHALL have port mem_addr, output, 32 bits: word address with bits [1:0] = 0.
REQ-016 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-017 SHALL have port mem_wstrb, output, 4 bits: byte-lane enables.
REQ-018 SHALL have port mem_ack, input, 1 bit: one-cycle completion pulse from memory.
REQ-019 SHALL have port mem_rdata, input, 32 bits: read word, valid with mem_ack.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL accept a request in IDLE when req_valid = 1 and register we, funct3, addr and wdata on that edge.
REQ-022 SHALL treat loads with funct3 in {000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu} and stores with funct3 in {000 sb, 001 sh, 010 sw} as legal; any other combination is illegal.
REQ-023 SHALL treat an access as misaligned when a halfword has addr[0] = 1 or a word has addr[1:0] != 0.
REQ-024 SHALL move from IDLE to RESP with err = 1 and perform no memory access for illegal or misaligned requests.
REQ-025 SHALL move legal, aligned requests from IDLE to ACCESS, with mem_req = 1 from the cycle after acceptance until mem_ack is sampled high.
REQ-026 SHALL hold mem_we, mem_addr, mem_wdata and mem_wstrb stable while mem_req = 1, and drive mem_wstrb = 0 for loads.
REQ-027 SHALL form store strobes as: sb 0001 << addr[1:0]; sh 0011 << addr[1:0]; sw 1111.
REQ-028 SHALL form store data as: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-029 SHALL count mem_ack only while mem_req = 1 (the first ACCESS cycle included); mem_ack in IDLE or RESP is ignored.
REQ-030 SHALL go from ACCESS to RESP on mem_ack, capturing the extended load data with err = 0.
REQ-031 SHALL select the load byte lane by addr[1:0] and the halfword by addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-032 SHALL count cycles in ACCESS with an 8-bit-or-wider counter; if TIMEOUT cycles pass without mem_ack, it drops mem_req and goes to RESP with err = 1.
REQ-033 SHALL leave RESP for IDLE after exactly one cycle, with resp_valid = 1 only in RESP.
REQ-034 SHALL drive resp_rdata = 0 for stores and for any response with err = 1.
REQ-035 SHALL give a legal access latency of: accept edge t, mem_req high at t+1, mem_ack at t+k (k >= 1), resp_valid at t+k+1, req_ready back at t+k+2.
REQ-036 SHALL give an error access latency of resp_valid at t+1.
REQ-037 SHALL let req_valid be don't-care outside IDLE; no request is queued.

Reset
REQ-038 SHALL, on rst_n = 0, enter IDLE and drive all outputs to 0 (including mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_*), except req_ready = 1, from the next edge onward.
REQ-039 SHALL, on reset during ACCESS, drop mem_req, produce no resp_valid, and ignore a mem_ack that arrives later.
REQ-040 SHALL clear the timeout counter on reset and on every entry to ACCESS.

Verification
REQ-041 SHALL verify lbu at 0x0000_0013 with mem_rdata 0x80FF_1234 and ack after 1 cycle -> mem_addr 0x10, mem_wstrb 0000, resp_rdata 0x0000_0080, resp_err 0, resp_valid 2 cycles after acceptance.
REQ-042 SHALL verify lh at 0x0000_0022 with mem_rdata 0x8001_7FFF -> resp_rdata 0xFFFF_8001; the same access as lhu -> 0x0000_8001.
REQ-043 SHALL verify sb at 0x0000_0105 with wdata 0x1234_56AB and ack delayed 3 cycles -> mem_wdata 0xABAB_ABAB, mem_wstrb 0010, mem_we 1, mem_req held 3 cycles, resp_rdata 0.
REQ-044 SHALL verify lw at 0x0000_0006, and a store with funct3 011 -> resp_valid at t+1 with resp_err 1, and mem_req never asserted.
REQ-045 SHALL verify TIMEOUT = 4 with no mem_ack -> mem_req high 4 cycles then low, resp_err 1; a stray mem_ack in the following IDLE cycle is ignored.
REQ-046 SHALL verify rst_n = 0 for 1 cycle during ACCESS of sw at 0x40 -> mem_req 0 and req_ready 1 after the edge, with no resp_valid even when mem_ack pulses afterwards.
